io_pull_sampler: RTL
====================

// Module: io_pull_sampler
// PURPOSE
//  Multi-channel pull-and-sample front end for bidirectional IO pins that have no
//  external pull resistors. Each period: drive the pins to a per-pin pull level,
//  release them to high-Z, wait a settle window, then sample. Samples are debounced
//  per pin and change-flagged. Sits between top-level inout pads and board logic
//  (buttons, DIP switches, jumpers).
// PARAMETERS
//  BIT_WIDTH      8  number of IO channels
//  DRIVE_CYCLES   2  cycles the pull level is driven per period (>=1)
//  SETTLE_CYCLES  2  cycles the pins float before sampling (>=0)
//  DEBOUNCE_COUNT 3  consecutive equal samples needed to update out (>=1)
// PORTS
//  clk         in    1          system clock
//  rst         in    1          synchronous reset, active-high
//  enable      in    1          1 = run sampling periods; 0 = idle, pins high-Z
//  pull_up_en  in    BIT_WIDTH  per pin: 1 = drive 1 in DRIVE, 0 = drive 0
//  io          inout BIT_WIDTH  pad pins
//  out         out   BIT_WIDTH  debounced pin values
//  out_valid   out   1          1-cycle strobe: a sample was processed
//  changed     out   BIT_WIDTH  1-cycle strobe per bit whose out toggled (with out_valid)
// BEHAVIOUR
//  - One clock domain; reset is synchronous and active-high. On reset: state=IDLE,
//    io all high-Z, out=0, out_valid=0, changed=0, phase and debounce counters=0.
//  - FSM: IDLE -> DRIVE (enable=1) -> SETTLE -> SAMPLE -> DRIVE ...
//    DRIVE: DRIVE_CYCLES cycles. SETTLE: SETTLE_CYCLES cycles; if 0, skipped
//    (DRIVE -> SAMPLE). SAMPLE: 1 cycle. Period = DRIVE+SETTLE+1 cycles.
//  - pull_up_en is registered on entry to DRIVE; changes apply from the next period.
//  - io = pull_reg only in DRIVE, high-Z in every other state. No pin is ever driven
//    in SETTLE or SAMPLE.
//  - io is captured at the clock edge ending SAMPLE. Per bit: sample==candidate ->
//    count increments, saturating at DEBOUNCE_COUNT. Otherwise candidate=sample and
//    count=1. When count reaches DEBOUNCE_COUNT and candidate!=out: out<=candidate and
//    changed[i]=1.
//  - out_valid and changed are registered outputs, high for the single cycle after
//    SAMPLE, which is the first DRIVE cycle. Latency from sample edge to out: 1 edge.
//  - DEBOUNCE_COUNT=1: out follows every sample.
//  - enable=0 seen in any state -> IDLE at the next edge. The partial period is
//    discarded (no out_valid), debounce counters are cleared, out holds its value.
//    Re-enable restarts at DRIVE with a full period.
//  - rst has priority over enable in every state.
//  - Counter widths: phase uses $clog2(max(DRIVE,SETTLE)+1); debounce uses
//    $clog2(DEBOUNCE_COUNT+1).
// STRUCTURE
//  - io_base_pkg: typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, SAMPLE} pull_state_t.
//  - Sub-module debounce_bit (count + candidate + out bit, params DEBOUNCE_COUNT),
//    instantiated BIT_WIDTH times via generate. The top holds the FSM, phase counter,
//    pull register and tristate assign.
// TESTING (BIT_WIDTH=8, DRIVE=2, SETTLE=2, DEBOUNCE=3, period=5)
//  1. rst=1 for 2 cycles, enable=1 -> io all Z during reset. out=0, out_valid=0, then
//     DRIVE on cycle after rst falls.
//  2. pull_up_en=8'h00, pads undriven (weak pull-down) -> io=0 for 2 cycles per period.
//     out_valid every 5 cycles. out stays 8'h00, changed=0.
//  3. External driver holds 8'hA5 while io is Z -> out becomes 8'hA5 with
//     changed=8'hA5 on the 3rd out_valid, not before.
//  4. Bit 0 toggles on alternate samples -> out[0] never changes, changed[0]=0 always.
//  5. enable falls mid-SETTLE -> IDLE next edge, no out_valid, out holds. Re-enable ->
//     3 more samples are needed before out updates.
//  6. pull_up_en changed mid-DRIVE from 8'h00 to 8'hFF -> the current period still
//     drives 0, the next DRIVE drives 8'hFF. SETTLE=0 build: period=3, out_valid every
//     3 cycles.

Source files
------------

// File: rtl/io_base_pkg.sv
// Shared types and helpers for the pull-and-sample IO front end.
package io_base_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        SAMPLE = 2'd3
    } pull_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One-pin debouncer: a candidate value must be seen DEBOUNCE_COUNT consecutive
// samples in a row before it is committed to the output bit.
module debounce_bit #(
    parameter int DEBOUNCE_COUNT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic sample_en,
    input  logic sample,
    output logic out_bit,
    output logic changed_bit
);

    localparam int CW = $clog2(DEBOUNCE_COUNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_COUNT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          cand_q, cand_d;
    logic          out_q, out_d;
    logic          chg_q, chg_d;

    always_comb begin
        cnt_d  = cnt_q;
        cand_d = cand_q;
        out_d  = out_q;
        chg_d  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (sample_en) begin
            if (sample == cand_q) begin
                cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
            end else begin
                cand_d = sample;
                cnt_d  = CW'(1);
            end
            if ((cnt_d == CNT_MAX) && (cand_d != out_q)) begin
                out_d = cand_d;
                chg_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            cand_q <= 1'b0;
            out_q  <= 1'b0;
            chg_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            cand_q <= cand_d;
            out_q  <= out_d;
            chg_q  <= chg_d;
        end
    end

    assign out_bit     = out_q;
    assign changed_bit = chg_q;

endmodule

// File: rtl/io_pull_sampler.sv
// Periodically pulls undriven pads to a per-pin level, floats them, samples
// after a settle window and debounces each pin.
module io_pull_sampler
    import io_base_pkg::*;
#(
    parameter int BIT_WIDTH      = 8,
    parameter int DRIVE_CYCLES   = 2,
    parameter int SETTLE_CYCLES  = 2,
    parameter int DEBOUNCE_COUNT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [BIT_WIDTH-1:0] pull_up_en,
    inout  wire  [BIT_WIDTH-1:0] io,
    output logic [BIT_WIDTH-1:0] out,
    output logic                 out_valid,
    output logic [BIT_WIDTH-1:0] changed
);

    localparam int PH_W = $clog2(max2(DRIVE_CYCLES, SETTLE_CYCLES) + 1);
    localparam logic [PH_W-1:0] DRV_LAST = PH_W'(DRIVE_CYCLES - 1);
    localparam logic [PH_W-1:0] SET_LAST = PH_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    pull_state_t          state_q, state_d;
    logic [PH_W-1:0]      phase_q, phase_d;
    logic [BIT_WIDTH-1:0] pull_q;
    logic                 out_valid_q;
    logic                 drive_en;
    logic                 sample_en;
    logic                 deb_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            out_valid_q <= sample_en;
        end
    end

    // Pull levels are latched only on entry to DRIVE so a period never changes mid-way.
    always_ff @(posedge clk) begin
        if ((state_q != DRIVE) && (state_d == DRIVE)) begin
            pull_q <= pull_up_en;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        if (!enable) begin
            state_d = IDLE;
            phase_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = DRIVE;
                    phase_d = '0;
                end
                DRIVE: begin
                    if (phase_q == DRV_LAST) begin
                        phase_d = '0;
                        state_d = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                SETTLE: begin
                    if (phase_q == SET_LAST) begin
                        phase_d = '0;
                        state_d = SAMPLE;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                SAMPLE: begin
                    state_d = DRIVE;
                    phase_d = '0;
                end
                default: begin
                    state_d = IDLE;
                    phase_d = '0;
                end
            endcase
        end
    end

    // A sample cut short by enable dropping is discarded, not processed.
    always_comb begin
        drive_en  = (state_q == DRIVE);
        sample_en = (state_q == SAMPLE) && enable;
        deb_clr   = !enable;
    end

    assign io        = drive_en ? pull_q : {BIT_WIDTH{1'bz}};
    assign out_valid = out_valid_q;

    for (genvar i = 0; i < BIT_WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
        ) u_deb (
            .clk        (clk),
            .rst        (rst),
            .clr        (deb_clr),
            .sample_en  (sample_en),
            .sample     (io[i]),
            .out_bit    (out[i]),
            .changed_bit(changed[i])
        );
    end

endmodule
